// File: rtl/sprite_mover.sv
// Bouncing square sprite: per-frame position update during vblank and a
// registered per-pixel hit/colour output for the downstream colour selector.
module sprite_mover #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned SIZE     = 32,
    parameter int unsigned STEP     = 2,
    parameter int unsigned X0       = 304,
    parameter int unsigned Y0       = 224
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       bright,
    input  logic       run,
    output logic       sprite_on,
    output logic [7:0] sprite_rgb,
    output logic [7:0] bounce_count,
    output logic       corner_hit,
    output logic       frame_tick
);

    localparam int unsigned CW = 10;
    localparam int unsigned SW = 11;
    localparam logic [SW-1:0] X_MAX  = SW'(H_ACTIVE - SIZE);
    localparam logic [SW-1:0] Y_MAX  = SW'(V_ACTIVE - SIZE);
    localparam logic [SW-1:0] STEP_W = SW'(STEP);
    localparam logic [SW-1:0] SIZE_W = SW'(SIZE);
    localparam logic [SW-1:0] VFS    = SW'(V_ACTIVE);

    // bit1 = dx (1: right), bit0 = dy (1: down)
    typedef enum logic [1:0] {
        DIR_UL = 2'b00,
        DIR_DL = 2'b01,
        DIR_UR = 2'b10,
        DIR_DR = 2'b11
    } dir_t;

    dir_t          dir_q, dir_d;
    logic          dx, dy;
    logic [CW-1:0] x_q, y_q, x_d, y_d;
    logic [2:0]    color_idx;
    logic          xb_c, yb_c, fs_c, hit_c;
    logic [SW-1:0] x_sum_c, y_sum_c, x_ext_c, y_ext_c, h_ext_c, v_ext_c;
    logic [7:0]    pal_c;

    // Direction state register
    always_ff @(posedge clk) begin
        if (rst) dir_q <= DIR_DR;
        else     dir_q <= dir_d;
    end

    // Next position/direction, evaluated only on the frame strobe while running
    always_comb begin
        x_ext_c = {1'b0, x_q};
        y_ext_c = {1'b0, y_q};
        h_ext_c = {1'b0, hcount};
        v_ext_c = {1'b0, vcount};
        x_sum_c = x_ext_c + STEP_W;
        y_sum_c = y_ext_c + STEP_W;
        fs_c    = (hcount == '0) && (v_ext_c == VFS);
        x_d     = x_q;
        y_d     = y_q;
        xb_c    = 1'b0;
        yb_c    = 1'b0;
        dir_d   = dir_q;
        if (fs_c && run) begin
            if (dx) begin
                if (x_sum_c >= X_MAX) begin x_d = CW'(X_MAX); xb_c = 1'b1; end
                else                        x_d = CW'(x_sum_c);
            end else begin
                if (x_ext_c <= STEP_W) begin x_d = '0; xb_c = 1'b1; end
                else                         x_d = CW'(x_ext_c - STEP_W);
            end
            if (dy) begin
                if (y_sum_c >= Y_MAX) begin y_d = CW'(Y_MAX); yb_c = 1'b1; end
                else                        y_d = CW'(y_sum_c);
            end else begin
                if (y_ext_c <= STEP_W) begin y_d = '0; yb_c = 1'b1; end
                else                         y_d = CW'(y_ext_c - STEP_W);
            end
            dir_d = dir_t'({dx ^ xb_c, dy ^ yb_c});
        end
    end

    // Direction decode
    always_comb begin
        dx = dir_q[1];
        dy = dir_q[0];
    end

    // Pixel hit test (half-open on the far edges) and palette lookup
    always_comb begin
        hit_c = bright
             && (h_ext_c >= x_ext_c) && (h_ext_c < x_ext_c + SIZE_W)
             && (v_ext_c >= y_ext_c) && (v_ext_c < y_ext_c + SIZE_W);
        case (color_idx)
            3'd0:    pal_c = 8'hE0;
            3'd1:    pal_c = 8'hFC;
            3'd2:    pal_c = 8'h1C;
            3'd3:    pal_c = 8'h1F;
            3'd4:    pal_c = 8'h03;
            3'd5:    pal_c = 8'hE3;
            3'd6:    pal_c = 8'hFF;
            default: pal_c = 8'h92;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q          <= CW'(X0);
            y_q          <= CW'(Y0);
            color_idx    <= '0;
            bounce_count <= '0;
            corner_hit   <= 1'b0;
            frame_tick   <= 1'b0;
            sprite_on    <= 1'b0;
            sprite_rgb   <= '0;
        end else begin
            x_q        <= x_d;
            y_q        <= y_d;
            frame_tick <= fs_c;
            corner_hit <= xb_c & yb_c;
            // A corner counts as a single bounce
            if (xb_c | yb_c) begin
                bounce_count <= bounce_count + 8'd1;
                color_idx    <= color_idx + 3'd1;
            end
            sprite_on  <= hit_c;
            sprite_rgb <= hit_c ? pal_c : 8'h00;
        end
    end

endmodule

// File: tb/tb_sprite_mover.sv
// Bench for sprite_mover: default instance plus a corner-start instance,
// a per-cycle reference model and directed literal checkpoints.
module tb_sprite_mover;

    logic       clk = 1'b0;
    logic       rst, run, bright;
    logic [9:0] hcount, vcount;

    logic       on_o [2];
    logic [7:0] rgb_o[2];
    logic [7:0] bc_o [2];
    logic       ch_o [2];
    logic       ft_o [2];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    sprite_mover u_a (
        .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .bright(bright), .run(run),
        .sprite_on(on_o[0]), .sprite_rgb(rgb_o[0]), .bounce_count(bc_o[0]),
        .corner_hit(ch_o[0]), .frame_tick(ft_o[0])
    );

    sprite_mover #(.X0(606), .Y0(446)) u_b (
        .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .bright(bright), .run(run),
        .sprite_on(on_o[1]), .sprite_rgb(rgb_o[1]), .bounce_count(bc_o[1]),
        .corner_hit(ch_o[1]), .frame_tick(ft_o[1])
    );

    // Reference model: position as an integer with a signed velocity, clamped at the walls
    int   pal[8] = '{'hE0, 'hFC, 'h1C, 'h1F, 'h03, 'hE3, 'hFF, 'h92};
    int   x0_t[2] = '{304, 606};
    int   y0_t[2] = '{224, 446};
    int   m_x[2], m_y[2], m_vx[2], m_vy[2], m_col[2], m_bc[2];
    int   e_on[2], e_rgb[2], e_bc[2], e_ch[2], e_ft[2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int  nx, ny, h, v;
            bit  xb, yb, fs;
            h = int'(hcount);
            v = int'(vcount);
            if (rst) begin
                m_x[k] = x0_t[k]; m_y[k] = y0_t[k];
                m_vx[k] = 2; m_vy[k] = 2; m_col[k] = 0; m_bc[k] = 0;
                e_on[k] = 0; e_rgb[k] = 0; e_ch[k] = 0; e_ft[k] = 0;
            end else begin
                e_on[k]  = (bright && h >= m_x[k] && h < m_x[k] + 32
                                   && v >= m_y[k] && v < m_y[k] + 32) ? 1 : 0;
                e_rgb[k] = e_on[k] ? pal[m_col[k]] : 0;
                fs       = (h == 0 && v == 480);
                e_ft[k]  = fs ? 1 : 0;
                e_ch[k]  = 0;
                if (fs && run) begin
                    xb = 0; yb = 0;
                    nx = m_x[k] + m_vx[k];
                    if (nx <= 0)        begin nx = 0;   m_vx[k] = 2;  xb = 1; end
                    else if (nx >= 608) begin nx = 608; m_vx[k] = -2; xb = 1; end
                    ny = m_y[k] + m_vy[k];
                    if (ny <= 0)        begin ny = 0;   m_vy[k] = 2;  yb = 1; end
                    else if (ny >= 448) begin ny = 448; m_vy[k] = -2; yb = 1; end
                    m_x[k] = nx; m_y[k] = ny;
                    if (xb || yb) begin
                        m_bc[k]  = (m_bc[k] + 1) % 256;
                        m_col[k] = (m_col[k] + 1) % 8;
                    end
                    e_ch[k] = (xb && yb) ? 1 : 0;
                end
            end
            e_bc[k] = m_bc[k];
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("dut%0d sprite_on", k),    int'(on_o[k]),  e_on[k]);
                check($sformatf("dut%0d sprite_rgb", k),   int'(rgb_o[k]), e_rgb[k]);
                check($sformatf("dut%0d bounce_count", k), int'(bc_o[k]),  e_bc[k]);
                check($sformatf("dut%0d corner_hit", k),   int'(ch_o[k]),  e_ch[k]);
                check($sformatf("dut%0d frame_tick", k),   int'(ft_o[k]),  e_ft[k]);
            end
        end
    end

    task automatic drive(input int h, input int v, input bit b);
        hcount = 10'(h);
        vcount = 10'(v);
        bright = b;
        @(negedge clk);
    endtask

    task automatic probe(input string name, input int h, input int v, input bit b,
                         input int k, input int exp_on, input int exp_rgb);
        drive(h, v, b);
        check({name, " on"},  int'(on_o[k]),  exp_on);
        check({name, " rgb"}, int'(rgb_o[k]), exp_rgb);
    endtask

    task automatic frame();
        drive(0, 480, 1'b0);
        check("frame_tick pulse", int'(ft_o[0]), 1);
        drive(1, 480, 1'b0);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; bright = 1'b0; hcount = '0; vcount = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            check("reset sprite_on", int'(on_o[k]), 0);
            check("reset rgb",       int'(rgb_o[k]), 0);
            check("reset bounce",    int'(bc_o[k]), 0);
            check("reset corner",    int'(ch_o[k]), 0);
            check("reset tick",      int'(ft_o[k]), 0);
        end
        rst = 1'b0;

        // Frozen sprite at reset position, line 224
        for (int h = 303; h <= 336; h++)
            probe("home scan", h, 224, 1'b1, 0, (h >= 304 && h <= 335) ? 1 : 0,
                  (h >= 304 && h <= 335) ? 'hE0 : 0);
        frame();
        check("tick one cycle", int'(ft_o[0]), 0);
        probe("frozen x", 304, 224, 1'b1, 0, 1, 'hE0);
        probe("frozen left", 303, 224, 1'b1, 0, 0, 0);

        // Moving: corner instance bounces on both axes at the first update
        run = 1'b1;
        drive(0, 480, 1'b0);
        check("corner pulse",  int'(ch_o[1]), 1);
        check("corner count",  int'(bc_o[1]), 1);
        check("no corner a",   int'(ch_o[0]), 0);
        drive(5, 0, 1'b0);
        check("corner single", int'(ch_o[1]), 0);
        probe("corner colour", 608, 448, 1'b1, 1, 1, 'hFC);
        probe("corner right",  607, 448, 1'b1, 1, 0, 0);
        frame();
        frame();
        probe("n3 left out",  309, 230, 1'b1, 0, 0, 0);
        probe("n3 left in",   310, 230, 1'b1, 0, 1, 'hE0);
        probe("n3 right in",  341, 230, 1'b1, 0, 1, 'hE0);
        probe("n3 right out", 342, 230, 1'b1, 0, 0, 0);
        probe("n3 top out",   310, 229, 1'b1, 0, 0, 0);
        check("n3 bounces", int'(bc_o[0]), 0);

        // Bottom bounce at update 112, right bounce at update 152
        repeat (149) frame();
        check("right edge count", int'(bc_o[0]), 2);
        probe("right edge", 608, 368, 1'b1, 0, 1, 'h1C);
        probe("right edge lo", 607, 368, 1'b1, 0, 0, 0);
        frame();
        probe("after right in",  606, 366, 1'b1, 0, 1, 'h1C);
        probe("after right out", 605, 366, 1'b1, 0, 0, 0);
        probe("after right far", 637, 366, 1'b1, 0, 1, 'h1C);
        probe("after right end", 638, 366, 1'b1, 0, 0, 0);

        // Top bounce at update 336, left bounce at update 456
        repeat (303) frame();
        check("left edge count", int'(bc_o[0]), 4);
        probe("left edge",     0, 240, 1'b1, 0, 1, 'h03);
        probe("left edge end", 32, 240, 1'b1, 0, 0, 0);
        frame();
        probe("after left in",  2, 242, 1'b1, 0, 1, 'h03);
        probe("after left out", 1, 242, 1'b1, 0, 0, 0);
        probe("blanked",        2, 242, 1'b0, 0, 0, 0);

        // Mid-line reset while the sprite is lit
        probe("pre reset", 3, 242, 1'b1, 0, 1, 'h03);
        rst = 1'b1;
        drive(4, 242, 1'b1);
        check("midline rst on",    int'(on_o[0]), 0);
        check("midline rst rgb",   int'(rgb_o[0]), 0);
        check("midline rst count", int'(bc_o[0]), 0);
        rst = 1'b0;
        probe("post reset home", 304, 224, 1'b1, 0, 1, 'hE0);

        // Reset coincident with the frame strobe wins
        rst = 1'b1;
        drive(0, 480, 1'b0);
        check("rst at fs tick", int'(ft_o[0]), 0);
        rst = 1'b0;
        probe("rst at fs home", 304, 224, 1'b1, 0, 1, 'hE0);
        probe("rst at fs left", 303, 224, 1'b1, 0, 0, 0);
        frame();
        probe("resume in",  306, 226, 1'b1, 0, 1, 'hE0);
        probe("resume out", 305, 226, 1'b1, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_mover.md
Name: sprite_mover

Overview:
Bouncing square sprite generator that sits directly upstream of the colour-selection stage, in parallel with the interrupt manager. It consumes the timing controller's hcount/vcount/bright and produces a registered per-pixel sprite hit flag plus 8-bit RGB (3/3/2) for the colour selector to overlay. Sprite position updates once per frame during vertical blanking, so there is no tearing. The sprite bounces off the screen edges, and its colour advances on every bounce.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
SIZE, 32, sprite edge length in pixels
STEP, 2, pixels moved per axis per frame
X0, 304, reset X position (left edge)
Y0, 224, reset Y position (top edge)

Ports:
clk  input  1  pixel clock (the divided clock that drives the timing controller); single clock domain
rst  input  1  synchronous, active-high reset
hcount  input  10  current pixel column from timing controller
vcount  input  10  current line from timing controller
bright  input  1  high inside visible area
run  input  1  1 = sprite moves at frame strobe; 0 = position frozen
sprite_on  output  1  registered: current pixel is inside sprite and visible
sprite_rgb  output  8  registered {r[2:0],g[2:0],b[1:0]}; 0 when sprite_on=0
bounce_count  output  8  wrapping count of bounce events
corner_hit  output  1  one-cycle pulse when X and Y bounce on the same update
frame_tick  output  1  one-cycle pulse at the frame-update strobe, asserted regardless of run

Behaviour:
- Reset is synchronous, active-high, and honoured mid-frame.
  - x=X0, y=Y0, dx=1 (right), dy=1 (down), color_idx=0.
  - sprite_on=0, sprite_rgb=0, bounce_count=0, corner_hit=0, frame_tick=0.
- Frame strobe: fs = (hcount==0 && vcount==V_ACTIVE). Because clk is the pixel clock, fs is true for exactly one cycle per frame.
- frame_tick is registered fs, one cycle later.
- Position update, on the cycle fs=1 and run=1. X shown; Y is identical using V_ACTIVE and dy. Sums are computed at 11 bits to avoid wrap.
  - dx=1 and x+STEP >= H_ACTIVE-SIZE: x <= H_ACTIVE-SIZE, dx <= 0, xb=1.
  - dx=0 and x <= STEP: x <= 0, dx <= 1, xb=1.
  - Otherwise: x <= x±STEP, xb=0.
- Bounce event = xb|yb.
  - Increments bounce_count (mod 256) and color_idx (mod 8) by exactly 1, even when both axes bounce.
  - corner_hit=1 on the following cycle iff xb&yb.
- run=0: x, y, dx, dy, color_idx and bounce_count hold; fs is still observed for frame_tick only.
- Pixel path, 1-cycle latency; compare with current registered x,y.
  - hit = bright && hcount>=x && hcount<x+SIZE && vcount>=y && vcount<y+SIZE.
  - Next cycle: sprite_on=hit, sprite_rgb = hit ? PALETTE[color_idx] : 0.
- PALETTE, idx 0..7: 0xE0, 0xFC, 0x1C, 0x1F, 0x03, 0xE3, 0xFF, 0x92.
- Position and colour change only at fs, which lies in vblank, so every visible pixel of a frame sees one consistent x, y and colour.
- Pixels at x+SIZE or y+SIZE are outside the sprite (half-open interval).
- If bright=0, sprite_on=0 even when coordinates fall inside the sprite.
- No state machine beyond the direction flags. dx/dy are a 2-bit direction state with 4 states (UR, UL, DR, DL). Transitions occur only at fs&run, per the rules above.

Test Plan:
- Reset then one frame with run=0, defaults, hcount=304..336 on line 224 → sprite_on=1 at hcount 304..335 (seen 1 clk later), rgb=0xE0; 0 at hcount 336; frame_tick pulses once per frame; x stays 304.
- run=1, 3 frames → x=310, y=230; bounce_count=0; sprite edges follow the new position only from the frame after each fs.
- Right-edge bounce, run=1: at x=606 → x=608, dx=0, bounce_count 1, color_idx 1, rgb 0xFC next frame; following frame x=606.
- Corner: rst with X0=606, Y0=446 → first update x=608, y=448, corner_hit single pulse, bounce_count=1 (not 2), both directions flipped.
- Left/top bounce, SIZE=32, STEP=2: x=2, dx=0 → x=0, dx=1; next update x=2.
- Assert rst mid-visible-line with sprite_on=1 → next cycle all outputs 0, x/y back to X0/Y0.
- Assert rst coincident with fs → reset wins, no position update.
- bright=0 inside sprite coordinates → sprite_on=0.
